// File: rtl/jtag_ir_driver.sv
// JTAG initiator that loads one IR_LEN-bit instruction through Shift-IR and returns the captured IR bits.
// Define JTAG_IR_DRIVER_TLR_EN to force the target through Test-Logic-Reset before every operation.
module jtag_ir_driver #(
  parameter int unsigned IR_LEN  = 4,
  parameter int unsigned TCK_DIV = 2
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [IR_LEN-1:0] Instr,
  output logic              Busy,
  output logic              Done,
  output logic [IR_LEN-1:0] Captured,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  localparam int unsigned CW = $clog2(IR_LEN + 6);
  localparam int unsigned DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

`ifdef JTAG_IR_DRIVER_TLR_EN
  typedef enum logic [2:0] {IDLE, TLR, HDR, SHIFT, TRL} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, SHIFT, TRL} state_t;
`endif

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     div_cnt;
  logic [IR_LEN-1:0] instr_sr;
  logic [IR_LEN-1:0] shadow;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state    <= IDLE;
      cnt      <= '0;
      div_cnt  <= '0;
      instr_sr <= '0;
      shadow   <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Captured <= '0;
      TCK      <= 1'b0;
      TMS      <= 1'b0;
      TDI      <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE) begin
        TCK <= 1'b0;
        TMS <= 1'b0;
        TDI <= 1'b0;
        if (Start && !Busy) begin
          instr_sr <= Instr;
          div_cnt  <= '0;
          cnt      <= '0;
          Busy     <= 1'b1;
          TMS      <= 1'b1;
`ifdef JTAG_IR_DRIVER_TLR_EN
          state    <= TLR;
`else
          state    <= HDR;
`endif
        end
      end else if (div_cnt != DW'(TCK_DIV - 1)) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!TCK) begin
          TCK <= 1'b1;
          // TDO is sampled as TCK rises; the target last changed it on the previous fall.
          if (state == SHIFT) shadow <= {TDO, shadow[IR_LEN-1:1]};
        end else begin
          // Falling edge: set TMS/TDI for the next rising edge, or finish.
          TCK <= 1'b0;
          cnt <= cnt + 1'b1;
          case (state)
`ifdef JTAG_IR_DRIVER_TLR_EN
            TLR: begin
              if (cnt == CW'(5)) begin
                state <= HDR;
                cnt   <= '0;
                TMS   <= 1'b1;
              end else begin
                TMS <= (cnt < CW'(4));
              end
            end
`endif
            HDR: begin
              if (cnt == CW'(3)) begin
                state <= SHIFT;
                cnt   <= '0;
                TMS   <= 1'b0;
                TDI   <= instr_sr[0];
              end else begin
                TMS <= (cnt == '0);
              end
            end
            SHIFT: begin
              if (cnt == CW'(IR_LEN - 1)) begin
                state <= TRL;
                cnt   <= '0;
                TMS   <= 1'b1;
                TDI   <= 1'b0;
              end else begin
                instr_sr <= instr_sr >> 1;
                TDI      <= instr_sr[1];
                TMS      <= (cnt == CW'(IR_LEN - 2));
              end
            end
            TRL: begin
              TMS <= 1'b0;
              if (cnt == CW'(1)) begin
                state    <= IDLE;
                cnt      <= '0;
                Busy     <= 1'b0;
                Done     <= 1'b1;
                Captured <= shadow;
                TDI      <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_ir_driver.sv
// Bench for jtag_ir_driver: two instances (TCK_DIV=2 and 1) driving behavioural TAP models,
// checked every cycle against a period-arithmetic model plus literal expectations.
module tb_jtag_ir_driver;

  localparam int IRL = 4;
  localparam logic [IRL-1:0] CAP = 4'b0101;
`ifdef JTAG_IR_DRIVER_TLR_EN
  localparam int PRE = 6;
  localparam int DONE0_LIT = 65;
  localparam int B2B_LIT = 33;
  localparam logic [15:0] TMS_LIT = 16'h60DF;
`else
  localparam int PRE = 0;
  localparam int DONE0_LIT = 41;
  localparam int B2B_LIT = 21;
  localparam logic [15:0] TMS_LIT = 16'h0183;
`endif
  localparam int N = PRE + 4 + IRL + 2;

  typedef enum logic [3:0] {T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR,
                            T_UDR, T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR} tap_t;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic ResetN = 1'b0;
  logic start [2];
  logic [IRL-1:0] instr [2];
  logic busy [2], done [2], tck [2], tms [2], tdi [2], tdo [2];
  logic [IRL-1:0] captured [2];

  jtag_ir_driver #(.IR_LEN(IRL), .TCK_DIV(2)) u_dut0 (
    .Clock(Clock), .ResetN(ResetN), .Start(start[0]), .Instr(instr[0]),
    .Busy(busy[0]), .Done(done[0]), .Captured(captured[0]),
    .TCK(tck[0]), .TMS(tms[0]), .TDI(tdi[0]), .TDO(tdo[0]));

  jtag_ir_driver #(.IR_LEN(IRL), .TCK_DIV(1)) u_dut1 (
    .Clock(Clock), .ResetN(ResetN), .Start(start[1]), .Instr(instr[1]),
    .Busy(busy[1]), .Done(done[1]), .Captured(captured[1]),
    .TCK(tck[1]), .TMS(tms[1]), .TDI(tdi[1]), .TDO(tdo[1]));

  function automatic int dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int endc(input int i);
    return 1 + N * 2 * dv(i);
  endfunction

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:  return m ? T_TLR  : T_RTI;
      T_RTI:  return m ? T_SDR  : T_RTI;
      T_SDR:  return m ? T_SIR  : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR  : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR  : T_SHDR;
      T_UDR:  return m ? T_SDR  : T_RTI;
      T_SIR:  return m ? T_TLR  : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR  : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR  : T_SHIR;
      default: return m ? T_SDR : T_RTI;
    endcase
  endfunction

  // Target TAP models, observed on the falling system clock so they never race the DUT.
  tap_t tap_st [2];
  tap_t tap_park [2];
  logic tap_init [2];
  logic tck_q [2];
  logic [IRL-1:0] tap_sr [2], tap_ir [2];
  logic tms_log [4096];
  logic tdi_log [4096];
  int n_edge0 = 0;

  always @(negedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (tap_init[i]) begin
        tap_st[i] <= tap_park[i];
        tap_sr[i] <= '0;
        tap_ir[i] <= '0;
        tdo[i]    <= 1'b0;
      end else if (tck[i] && !tck_q[i]) begin
        if (tap_st[i] == T_CIR) tap_sr[i] <= CAP;
        else if (tap_st[i] == T_SHIR) tap_sr[i] <= {tdi[i], tap_sr[i][IRL-1:1]};
        if (tap_st[i] == T_UIR) tap_ir[i] <= tap_sr[i];
        tap_st[i] <= tap_next(tap_st[i], tms[i]);
        if (i == 0 && n_edge0 < 4096) begin
          tms_log[n_edge0] <= tms[0];
          tdi_log[n_edge0] <= tdi[0];
          n_edge0 <= n_edge0 + 1;
        end
      end else if (!tck[i] && tck_q[i]) begin
        tdo[i] <= (tap_st[i] == T_SHIR) ? tap_sr[i][0] : 1'b0;
      end
      tck_q[i] <= tck[i];
    end
  end

  // Reference model: t = cycles since acceptance (1 = first busy cycle).
  bit m_act [2];
  int m_t [2];
  logic [IRL-1:0] m_lat [2], m_cap [2];
  int cyc = 0;

  always @(posedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      bit bz;
      if (!ResetN) begin
        m_act[i] = 1'b0;
        m_t[i]   = 0;
        m_cap[i] = '0;
      end else begin
        bz = m_act[i] && (m_t[i] < endc(i));
        if (start[i] && !bz) begin
          m_act[i] = 1'b1;
          m_t[i]   = 1;
          m_lat[i] = instr[i];
        end else if (m_act[i]) begin
          if (m_t[i] == endc(i)) m_act[i] = 1'b0;
          else m_t[i] = m_t[i] + 1;
        end
        if (m_act[i] && m_t[i] == endc(i)) m_cap[i] = CAP;
      end
    end
    cyc = cyc + 1;
  end

  // {TCK,TMS,TDI,Busy,Done} from period number and phase.
  function automatic logic [4:0] exp_ctl(input bit act, input int t, input int d, input logic [IRL-1:0] li);
    int p, ph, q;
    logic k_tck, k_tms, k_tdi;
    logic [IRL-1:0] sh;
    if (!act) return 5'b00000;
    if (t == 1 + N * 2 * d) return 5'b00001;
    p = (t - 1) / (2 * d);
    ph = (t - 1) % (2 * d);
    k_tck = (ph >= d);
    k_tdi = 1'b0;
    if (p < PRE) begin
      k_tms = (p < PRE - 1);
    end else begin
      q = p - PRE;
      if (q < 4) k_tms = (q < 2);
      else if (q < 4 + IRL) begin
        k_tms = (q - 4 == IRL - 1);
        sh = li >> (q - 4);
        k_tdi = sh[0];
      end else k_tms = (q - 4 - IRL == 0);
    end
    return {k_tck, k_tms, k_tdi, 1'b1, 1'b0};
  endfunction

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    logic [4+IRL:0] g, x;
    @(negedge Clock);
    for (int i = 0; i < 2; i++) begin
      x = {exp_ctl(m_act[i], m_t[i], dv(i), m_lat[i]), m_cap[i]};
      g = {tck[i], tms[i], tdi[i], busy[i], done[i], captured[i]};
      n_checks++;
      if (g !== x) begin
        n_fail++;
        $display("FAIL outputs inst%0d cycle %0d: got tck,tms,tdi,busy,done,cap=%b expected %b", i, cyc, g, x);
      end
      if (m_act[i] && m_t[i] == endc(i)) begin
        n_checks++;
        if (tap_ir[i] !== m_lat[i]) begin
          n_fail++;
          $display("FAIL tap_ir inst%0d cycle %0d: got %h expected %h", i, cyc, tap_ir[i], m_lat[i]);
        end
      end
    end
  endtask

  task automatic run_until_done(input int i, input int maxc, output int dcyc);
    dcyc = -1;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (done[i] === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_done inst%0d: no Done within %0d cycles", i, maxc);
    end
  endtask

  initial begin
    int acc, d, d2, base, nd;
    logic [15:0] got_tms;
    logic [IRL-1:0] got_tdi;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      instr[i] = '0;
      tap_init[i] = 1'b1;
      tap_park[i] = T_RTI;
    end

    // Reset
    repeat (3) tick();
    chk("reset_inst0", {tck[0], tms[0], tdi[0], busy[0], done[0], captured[0]}, 0);
    chk("reset_inst1", {tck[1], tms[1], tdi[1], busy[1], done[1], captured[1]}, 0);
    ResetN = 1'b1;
    tap_init[0] = 1'b0;
    tap_init[1] = 1'b0;
    repeat (2) tick();

    // Basic load
    instr[0] = 4'b1010; start[0] = 1'b1; acc = cyc; base = n_edge0;
    tick();
    start[0] = 1'b0;
    run_until_done(0, 200, d);
    chk("basic_done_cycle", d - acc, DONE0_LIT);
    got_tms = '0;
    for (int j = 0; j < N; j++) got_tms = got_tms | (16'(tms_log[base + j]) << j);
    chk("basic_tms_seq", got_tms, TMS_LIT);
    got_tdi = '0;
    for (int k = 0; k < IRL; k++) got_tdi = got_tdi | (IRL'(tdi_log[base + PRE + 4 + k]) << k);
    chk("basic_tdi_shift", got_tdi, 4'b1010);
    chk("basic_model_ir", tap_ir[0], 4'b1010);
    chk("basic_captured", captured[0], 4'b0101);
    tick();

    // Busy collision
    instr[0] = 4'h3; start[0] = 1'b1; acc = cyc;
    tick();
    start[0] = 1'b0;
    while (cyc < acc + 10) tick();
    instr[0] = 4'hC; start[0] = 1'b1;
    tick();
    start[0] = 1'b0; instr[0] = 4'hF;
    nd = 0; d = -1;
    while (cyc < acc + 120) begin
      tick();
      if (done[0] === 1'b1) begin
        nd++;
        if (d < 0) d = cyc;
      end
    end
    chk("collision_done_count", nd, 1);
    chk("collision_done_cycle", d - acc, DONE0_LIT);
    chk("collision_model_ir", tap_ir[0], 4'h3);

    // Back-to-back on the TCK_DIV=1 instance
    instr[1] = 4'h6; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    run_until_done(1, 200, d);
    chk("b2b_first_ir", tap_ir[1], 4'h6);
    instr[1] = 4'h9; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    chk("b2b_busy_again", busy[1], 1);
    run_until_done(1, 200, d2);
    chk("b2b_spacing", d2 - d, B2B_LIT);
    chk("b2b_model_ir", tap_ir[1], 4'h9);

    // Reset during shift bit 2
    instr[0] = 4'h7; start[0] = 1'b1; base = n_edge0;
    tick();
    start[0] = 1'b0;
    for (int c = 0; c < 200 && n_edge0 < base + PRE + 6; c++) tick();
    repeat (3) tick();
    ResetN = 1'b0;
    tick();
    chk("midreset_outputs", {tck[0], tms[0], tdi[0], busy[0], done[0], captured[0]}, 0);
    tap_init[0] = 1'b1;
    tick();
    chk("midreset_no_done", done[0], 0);
    tick();
    ResetN = 1'b1; tap_init[0] = 1'b0;
    tick();
    instr[0] = 4'hA; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    run_until_done(0, 200, d);
    chk("midreset_model_ir", tap_ir[0], 4'hA);
    tick();

`ifdef JTAG_IR_DRIVER_TLR_EN
    // Target parked in Shift-DR; the TLR preamble must recover it
    tap_park[0] = T_SHDR; tap_init[0] = 1'b1;
    repeat (2) tick();
    tap_init[0] = 1'b0;
    tick();
    instr[0] = 4'h5; start[0] = 1'b1; acc = cyc; base = n_edge0;
    tick();
    start[0] = 1'b0;
    run_until_done(0, 200, d);
    got_tms = '0;
    for (int j = 0; j < 6; j++) got_tms = got_tms | (16'(tms_log[base + j]) << j);
    chk("tlr_first_six_tms", got_tms, 16'h001F);
    chk("tlr_done_cycle", d - acc, 65);
    chk("tlr_model_ir", tap_ir[0], 4'h5);
    tap_park[0] = T_RTI;
    tick();
`endif

    // Random traffic on both instances, including Start while busy and in Done cycles
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(0, 5) == 0);
        instr[i] = IRL'($urandom);
      end
      tick();
    end
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (150) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_ir_driver.md
# jtag_ir_driver

JTAG initiator that walks a target TAP from Run-Test/Idle through Select-IR, Capture-IR, Shift-IR, Exit1-IR and Update-IR, and back to Run-Test/Idle, loading one instruction of IR_LEN bits. It drives TCK, TMS and TDI from the system clock, and returns the IR capture value shifted out on TDO. It sits on the tester/bench side of the ripple-adder JTAG chain and drives the chain of instruction cells in the TAP.

## Interface
Parameters:
- IR_LEN, 4: instruction register length in bits, minimum 2.
- TCK_DIV, 2: Clock cycles per TCK half-period, minimum 1.

Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- ResetN  in  1  reset, synchronous, active-low.
- Start  in  1  request; accepted only in a cycle with Busy=0.
- Instr  in  IR_LEN  instruction; latched when Start is accepted, shifted LSB first.
- Busy  out  1  high from the cycle after acceptance until the Done cycle, exclusive.
- Done  out  1  one-cycle pulse at the end of an operation.
- Captured  out  IR_LEN  bits sampled from TDO during Shift-IR, LSB first; updated with Done, held otherwise.
- TCK  out  1  test clock; idles low.
- TMS  out  1  test mode select.
- TDI  out  1  test data to the target.
- TDO  in  1  test data from the target.

## Operation
- FSM states: IDLE, TLR (present only with the macro), HDR, SHIFT, TRL.
- IDLE: TCK=0, TMS=0. Start with Busy=0 latches Instr and moves to TLR if built, else to HDR.
- TMS and TDI change only while TCK is low. The value for rising edge n is set in the cycle in which TCK falls after edge n-1. For edge 1 it is set in the cycle after acceptance.
- HDR: 4 TCK periods with TMS = 1,1,0,0, reaching Shift-IR. TDI=0.
- SHIFT: IR_LEN periods. Before shift edge k (k = 0..IR_LEN-1):
  - TDI = Instr[k].
  - TMS = 0 for k < IR_LEN-1; TMS = 1 on the last bit, moving the target to Exit1-IR.
- TDO is sampled on each TCK rising edge in SHIFT into bit k of a shadow register.
- TRL: 2 periods with TMS = 1,0, through Update-IR to Run-Test/Idle. TDI=0.
- End of operation: in the cycle TCK falls after the last TRL period:
  - Done=1 and Busy=0.
  - Captured loads the shadow register.
  - Return to IDLE.
- Start while Busy=1 is ignored; Instr changes while busy have no effect.
- Start in the Done cycle is accepted, so operations run back-to-back.
- ResetN=0 at any time, including mid-shift, sets on the next edge:
  - state IDLE;
  - TCK=0, TMS=0, TDI=0;
  - Busy=0, Done=0, Captured=0.
  - The target TAP state is then undefined unless the TLR macro is built in.

## Timing
- TCK period is 2*TCK_DIV Clock cycles: TCK_DIV cycles low, then TCK_DIV cycles high.
- The first TCK rise occurs TCK_DIV cycles after Busy rises.
- Rising edges per operation: IR_LEN+6 without the macro, IR_LEN+12 with it.
- Start acceptance cycle is cycle 0. Done is asserted at cycle 1 + edges*2*TCK_DIV.
  - IR_LEN=4, TCK_DIV=2: Done at cycle 41 without the macro, 65 with it.
- Done is exactly one cycle wide.
- Captured is stable from the Done cycle until the next Done.

## Configuration
- JTAG_IR_DRIVER_TLR_EN defined:
  - Every operation starts in state TLR: 5 TCK periods with TMS=1, then 1 period with TMS=0, before HDR.
  - This forces the target to Test-Logic-Reset and then Run-Test/Idle from any state.
- Not defined:
  - The TLR state and its counter logic are absent.
  - The target is required to already be in Run-Test/Idle at Start.

## Test plan
- Reset: hold ResetN=0 for 3 cycles -> TCK=0, TMS=0, TDI=0, Busy=0, Done=0, Captured=0.
- Basic load, IR_LEN=4, TCK_DIV=2, macro off. Bench TAP model with 4 instruction cells, capture value 4'b0101. Start with Instr=4'b1010 ->
  - TMS at successive rising edges = 1,1,0,0,0,0,0,1,1,0;
  - TDI at the shift edges = 0,1,0,1;
  - Done at cycle 41; model IR = 4'b1010; Captured = 4'b0101.
- Busy collision: Start with Instr=4'h3, then Start with Instr=4'hC at cycle 10 -> only one Done, at cycle 41; model IR = 4'h3.
- Back-to-back, TCK_DIV=1: Start 4'h6, then Start 4'h9 in the first Done cycle ->
  - second operation begins immediately;
  - second Done 21 cycles after the first;
  - model IR = 4'h9.
- Reset mid-shift: drop ResetN during SHIFT bit 2 -> next cycle all outputs at reset values, no Done. After release, reset the model and Start 4'hA -> model IR = 4'hA.
- Macro on: Start 4'h5 with the model parked in Shift-DR ->
  - first six TMS values = 1,1,1,1,1,0;
  - Done at cycle 65; model IR = 4'h5.
